// File: rtl/mux2_rr_merge.sv
// -----------------------------------------------------------------------------
// mux2_rr_merge
//   Two-channel round-robin merge with a registered output stage. Words from
//   A0 and A1 (valid/ready streams) are arbitrated and registered onto Z. SL
//   carries the source index of the word held in Z, so a downstream 2:1 mux
//   array stays aligned with Z. In packet mode a grant is held until a LAST
//   beat, and a beat-count watchdog forces a release on runaway packets.
//
// Ports
//   CK                       clock, rising edge
//   RN                       asynchronous active-low reset
//   A0, A0_VALID, A0_LAST    channel 0 data / valid / last beat
//   A0_READY                 channel 0 accept (combinational)
//   A1, A1_VALID, A1_LAST    channel 1 data / valid / last beat
//   A1_READY                 channel 1 accept (combinational)
//   Z, Z_VALID, Z_LAST       registered output data / valid / last
//                            (Z_LAST is also set on a forced release)
//   Z_READY                  downstream accept
//   SL                       registered source index of Z (0 = A0, 1 = A1)
//   LOCKED                   high while a packet grant is held
//   ERR                      one-cycle pulse on a watchdog forced release
// -----------------------------------------------------------------------------
module mux2_rr_merge #(
    parameter int WIDTH       = 32,
    parameter int PACKET_MODE = 1,
    parameter int MAX_BEATS   = 16,
    parameter int CNT_W       = 5
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A0,
    input  logic             A0_VALID,
    input  logic             A0_LAST,
    output logic             A0_READY,
    input  logic [WIDTH-1:0] A1,
    input  logic             A1_VALID,
    input  logic             A1_LAST,
    output logic             A1_READY,
    output logic [WIDTH-1:0] Z,
    output logic             Z_VALID,
    output logic             Z_LAST,
    input  logic             Z_READY,
    output logic             SL,
    output logic             LOCKED,
    output logic             ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic             pri, pri_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             locked_nxt;

    logic             ld;
    logic             gnt;
    logic             gnt_vld;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;
    logic             forced;

    // The output register can take a new word when it is empty or being drained.
    assign ld = !Z_VALID || Z_READY;

    // Grant, handshake and next-state logic.
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        gnt        = 1'b0;
        gnt_vld    = 1'b0;
        state_nxt  = state;
        pri_nxt    = pri;
        cnt_nxt    = cnt;
        locked_nxt = LOCKED;
        forced     = 1'b0;

        unique case (state)
            IDLE: begin
                if (A0_VALID && A1_VALID) begin
                    gnt_vld = 1'b1;
                    gnt     = pri;
                end else if (A0_VALID) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b0;
                end else if (A1_VALID) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b1;
                end
            end
            // A locked grant stalls the other channel even while the owner
            // has no word to offer; bubbles are accepted for that.
            LOCK0: begin
                gnt_vld = 1'b1;
                gnt     = 1'b0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt     = 1'b1;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt     = 1'b0;
            end
        endcase

        sel_valid = gnt ? A1_VALID : A0_VALID;
        sel_last  = gnt ? A1_LAST  : A0_LAST;
        sel_data  = gnt ? A1       : A0;

        A0_READY = ld && gnt_vld && !gnt && RN;
        A1_READY = ld && gnt_vld &&  gnt && RN;
        xfer     = ld && gnt_vld && sel_valid && RN;

        if (xfer) begin
            if (state == IDLE) begin
                if ((PACKET_MODE != 0) && !sel_last) begin
                    state_nxt  = gnt ? LOCK1 : LOCK0;
                    cnt_nxt    = CNT_ONE;
                    locked_nxt = 1'b1;
                end else begin
                    pri_nxt = ~gnt;
                end
            end else if (sel_last || (cnt == CNT_LIMIT)) begin
                // Packet end, either real or forced by the watchdog. The
                // counter cannot pass CNT_LIMIT, so it never wraps.
                forced     = !sel_last;
                state_nxt  = IDLE;
                pri_nxt    = ~gnt;
                cnt_nxt    = '0;
                locked_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
    end

    // Control state registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            pri    <= 1'b0;
            cnt    <= '0;
            LOCKED <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= state_nxt;
            pri    <= pri_nxt;
            cnt    <= cnt_nxt;
            LOCKED <= locked_nxt;
            ERR    <= forced;
        end
    end

    // Output stage: load on transfer, drain when emptied without a refill,
    // hold Z/Z_LAST/SL otherwise.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            Z       <= '0;
            Z_VALID <= 1'b0;
            Z_LAST  <= 1'b0;
            SL      <= 1'b0;
        end else if (xfer) begin
            Z       <= sel_data;
            Z_LAST  <= sel_last || forced;
            SL      <= gnt;
            Z_VALID <= 1'b1;
        end else if (ld) begin
            Z_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_merge.sv
// -----------------------------------------------------------------------------
// tb_mux2_rr_merge
//   Directed bench for mux2_rr_merge. Two instances share clock and reset:
//   u_rr runs with PACKET_MODE=0, u_pk with PACKET_MODE=1 and MAX_BEATS=4.
//   Inputs change 1 time unit after the rising edge; combinational READY is
//   checked 1 unit later, registered outputs 1 unit after the next edge.
// -----------------------------------------------------------------------------
module tb_mux2_rr_merge;

    logic        CK;
    logic        RN;

    // u_rr signals
    logic [31:0] r_a0, r_a1, r_z;
    logic        r_a0_valid, r_a0_last, r_a0_ready;
    logic        r_a1_valid, r_a1_last, r_a1_ready;
    logic        r_z_valid, r_z_last, r_z_ready, r_sl, r_locked, r_err;

    // u_pk signals
    logic [31:0] p_a0, p_a1, p_z;
    logic        p_a0_valid, p_a0_last, p_a0_ready;
    logic        p_a1_valid, p_a1_last, p_a1_ready;
    logic        p_z_valid, p_z_last, p_z_ready, p_sl, p_locked, p_err;

    int n_checks = 0;
    int n_fail   = 0;

    mux2_rr_merge #(.WIDTH(32), .PACKET_MODE(0), .MAX_BEATS(16), .CNT_W(5)) u_rr (
        .CK(CK), .RN(RN),
        .A0(r_a0), .A0_VALID(r_a0_valid), .A0_LAST(r_a0_last), .A0_READY(r_a0_ready),
        .A1(r_a1), .A1_VALID(r_a1_valid), .A1_LAST(r_a1_last), .A1_READY(r_a1_ready),
        .Z(r_z), .Z_VALID(r_z_valid), .Z_LAST(r_z_last), .Z_READY(r_z_ready),
        .SL(r_sl), .LOCKED(r_locked), .ERR(r_err)
    );

    mux2_rr_merge #(.WIDTH(32), .PACKET_MODE(1), .MAX_BEATS(4), .CNT_W(5)) u_pk (
        .CK(CK), .RN(RN),
        .A0(p_a0), .A0_VALID(p_a0_valid), .A0_LAST(p_a0_last), .A0_READY(p_a0_ready),
        .A1(p_a1), .A1_VALID(p_a1_valid), .A1_LAST(p_a1_last), .A1_READY(p_a1_ready),
        .Z(p_z), .Z_VALID(p_z_valid), .Z_LAST(p_z_last), .Z_READY(p_z_ready),
        .SL(p_sl), .LOCKED(p_locked), .ERR(p_err)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic p_drive(input logic a0v, input logic [31:0] a0, input logic a0l,
                           input logic a1v, input logic [31:0] a1, input logic a1l);
        p_a0_valid = a0v; p_a0 = a0; p_a0_last = a0l;
        p_a1_valid = a1v; p_a1 = a1; p_a1_last = a1l;
    endtask

    task automatic do_reset();
        RN = 1'b0;
        tick();
        tick();
        RN = 1'b1;
    endtask

    task automatic test_reset();
        p_drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        p_z_ready = 1'b1;
        #2 RN = 1'b0;
        #1;
        n_checks++; if (p_z_valid !== 1'b0) begin n_fail++; $display("FAIL reset_z_valid: got %b want 0", p_z_valid); end
        n_checks++; if (p_a0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a0_ready: got %b want 0", p_a0_ready); end
        n_checks++; if (p_a1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a1_ready: got %b want 0", p_a1_ready); end
        n_checks++; if (p_sl !== 1'b0) begin n_fail++; $display("FAIL reset_sl: got %b want 0", p_sl); end
        n_checks++; if (p_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", p_locked); end
        n_checks++; if (p_z !== 32'h0) begin n_fail++; $display("FAIL reset_z: got %h want 0", p_z); end
        tick();
        tick();
        p_drive(1'b1, 32'h11, 1'b1, 1'b0, 32'h0, 1'b0);
        RN = 1'b1;
        #1;
        n_checks++; if (p_a0_ready !== 1'b1) begin n_fail++; $display("FAIL first_a0_ready: got %b want 1", p_a0_ready); end
        tick();
        n_checks++; if (p_z !== 32'h11) begin n_fail++; $display("FAIL first_z: got %h want 11", p_z); end
        n_checks++; if (p_sl !== 1'b0) begin n_fail++; $display("FAIL first_sl: got %b want 0", p_sl); end
        n_checks++; if (p_z_valid !== 1'b1) begin n_fail++; $display("FAIL first_z_valid: got %b want 1", p_z_valid); end
        p_a0_valid = 1'b0;
        tick();
        n_checks++; if (p_z_valid !== 1'b0) begin n_fail++; $display("FAIL drain_z_valid: got %b want 0", p_z_valid); end
        n_checks++; if (p_z !== 32'h11) begin n_fail++; $display("FAIL drain_z_hold: got %h want 11", p_z); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_z;
        r_a0 = 32'hA0A0; r_a0_valid = 1'b1; r_a0_last = 1'b1;
        r_a1 = 32'hA1A1; r_a1_valid = 1'b1; r_a1_last = 1'b1;
        r_z_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (r_a0_ready !== (k % 2 == 0)) begin n_fail++; $display("FAIL rr_a0_ready[%0d]: got %b want %b", k, r_a0_ready, (k % 2 == 0)); end
            n_checks++; if (r_a1_ready !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_a1_ready[%0d]: got %b want %b", k, r_a1_ready, (k % 2 == 1)); end
            tick();
            exp_z = (k % 2 == 0) ? 32'hA0A0 : 32'hA1A1;
            n_checks++; if (r_z !== exp_z) begin n_fail++; $display("FAIL rr_z[%0d]: got %h want %h", k, r_z, exp_z); end
            n_checks++; if (r_sl !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_sl[%0d]: got %b want %b", k, r_sl, (k % 2 == 1)); end
            n_checks++; if (r_z_valid !== 1'b1) begin n_fail++; $display("FAIL rr_z_valid[%0d]: got %b want 1", k, r_z_valid); end
            n_checks++; if (r_locked !== 1'b0) begin n_fail++; $display("FAIL rr_locked[%0d]: got %b want 0", k, r_locked); end
        end
        r_a0_valid = 1'b0;
        r_a1_valid = 1'b0;
        tick();
    endtask

    task automatic test_packet_lock();
        logic [31:0] beats [3];
        beats[0] = 32'hA; beats[1] = 32'hB; beats[2] = 32'hC;
        do_reset();
        p_z_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p_drive(1'b1, beats[k], (k == 2), 1'b1, 32'h1B1, 1'b1);
            #1;
            n_checks++; if (p_a1_ready !== 1'b0) begin n_fail++; $display("FAIL pkt_a1_ready[%0d]: got %b want 0", k, p_a1_ready); end
            n_checks++; if (p_a0_ready !== 1'b1) begin n_fail++; $display("FAIL pkt_a0_ready[%0d]: got %b want 1", k, p_a0_ready); end
            tick();
            n_checks++; if (p_z !== beats[k]) begin n_fail++; $display("FAIL pkt_z[%0d]: got %h want %h", k, p_z, beats[k]); end
            n_checks++; if (p_z_last !== (k == 2)) begin n_fail++; $display("FAIL pkt_z_last[%0d]: got %b want %b", k, p_z_last, (k == 2)); end
            n_checks++; if (p_locked !== (k != 2)) begin n_fail++; $display("FAIL pkt_locked[%0d]: got %b want %b", k, p_locked, (k != 2)); end
        end
        p_a0_valid = 1'b0;
        #1;
        n_checks++; if (p_a1_ready !== 1'b1) begin n_fail++; $display("FAIL pkt_a1_granted: got %b want 1", p_a1_ready); end
        tick();
        n_checks++; if (p_z !== 32'h1B1) begin n_fail++; $display("FAIL pkt_a1_z: got %h want 1b1", p_z); end
        n_checks++; if (p_sl !== 1'b1) begin n_fail++; $display("FAIL pkt_a1_sl: got %b want 1", p_sl); end
        p_a1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        p_z_ready = 1'b1;
        p_drive(1'b1, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        p_drive(1'b1, 32'h66, 1'b1, 1'b1, 32'h77, 1'b1);
        p_z_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (p_z !== 32'h55) begin n_fail++; $display("FAIL bp_z[%0d]: got %h want 55", k, p_z); end
            n_checks++; if (p_sl !== 1'b0) begin n_fail++; $display("FAIL bp_sl[%0d]: got %b want 0", k, p_sl); end
            n_checks++; if (p_z_valid !== 1'b1) begin n_fail++; $display("FAIL bp_z_valid[%0d]: got %b want 1", k, p_z_valid); end
            n_checks++; if ((p_a0_ready | p_a1_ready) !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b%b want 00", k, p_a0_ready, p_a1_ready); end
            tick();
        end
        p_z_ready = 1'b1;
        #1;
        n_checks++; if (p_a1_ready !== 1'b1 || p_a0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release_ready: got %b%b want 01", p_a0_ready, p_a1_ready); end
        tick();
        n_checks++; if (p_z !== 32'h77) begin n_fail++; $display("FAIL bp_next_z: got %h want 77", p_z); end
        n_checks++; if (p_sl !== 1'b1) begin n_fail++; $display("FAIL bp_next_sl: got %b want 1", p_sl); end
        p_a1_valid = 1'b0;
        tick();
        n_checks++; if (p_z !== 32'h66 || p_z_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_z: got %h/%b want 66/1", p_z, p_z_valid); end
        p_a0_valid = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        p_z_ready = 1'b1;
        p_drive(1'b1, 32'h99, 1'b1, 1'b1, 32'h1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (p_z !== 32'(k)) begin n_fail++; $display("FAIL wd_z[%0d]: got %h want %h", k, p_z, 32'(k)); end
            n_checks++; if (p_z_last !== 1'b0) begin n_fail++; $display("FAIL wd_z_last[%0d]: got %b want 0", k, p_z_last); end
            n_checks++; if (p_err !== 1'b0) begin n_fail++; $display("FAIL wd_err[%0d]: got %b want 0", k, p_err); end
            n_checks++; if (p_locked !== 1'b1) begin n_fail++; $display("FAIL wd_locked[%0d]: got %b want 1", k, p_locked); end
            p_a1 = 32'(k + 1);
        end
        tick();
        p_a1 = 32'h5;
        n_checks++; if (p_z !== 32'h4 || p_z_last !== 1'b1) begin n_fail++; $display("FAIL wd_forced_beat: got %h/%b want 4/1", p_z, p_z_last); end
        n_checks++; if (p_err !== 1'b1) begin n_fail++; $display("FAIL wd_err_pulse: got %b want 1", p_err); end
        n_checks++; if (p_locked !== 1'b0) begin n_fail++; $display("FAIL wd_unlocked: got %b want 0", p_locked); end
        #1;
        n_checks++; if (p_a0_ready !== 1'b1 || p_a1_ready !== 1'b0) begin n_fail++; $display("FAIL wd_a0_next: got %b%b want 10", p_a0_ready, p_a1_ready); end
        tick();
        n_checks++; if (p_z !== 32'h99 || p_sl !== 1'b0) begin n_fail++; $display("FAIL wd_a0_z: got %h/%b want 99/0", p_z, p_sl); end
        n_checks++; if (p_err !== 1'b0) begin n_fail++; $display("FAIL wd_err_clear: got %b want 0", p_err); end
    endtask

    task automatic test_reset_mid_packet();
        p_z_ready = 1'b1;
        p_drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h21, 1'b0);
        tick();
        n_checks++; if (p_z !== 32'h21 || p_locked !== 1'b1 || p_sl !== 1'b1) begin n_fail++; $display("FAIL mid_beat1: got %h/%b/%b want 21/1/1", p_z, p_locked, p_sl); end
        p_a1 = 32'h22;
        tick();
        n_checks++; if (p_z !== 32'h22 || p_locked !== 1'b1) begin n_fail++; $display("FAIL mid_beat2: got %h/%b want 22/1", p_z, p_locked); end
        #2 RN = 1'b0;
        #1;
        n_checks++; if (p_z_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_z_valid: got %b want 0", p_z_valid); end
        n_checks++; if (p_locked !== 1'b0) begin n_fail++; $display("FAIL mid_rst_locked: got %b want 0", p_locked); end
        n_checks++; if (p_sl !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sl: got %b want 0", p_sl); end
        p_drive(1'b1, 32'h31, 1'b1, 1'b1, 32'h32, 1'b1);
        #1 RN = 1'b1;
        #1;
        n_checks++; if (p_a0_ready !== 1'b1 || p_a1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_tie_ready: got %b%b want 10", p_a0_ready, p_a1_ready); end
        tick();
        n_checks++; if (p_z !== 32'h31 || p_sl !== 1'b0 || p_z_valid !== 1'b1) begin n_fail++; $display("FAIL mid_tie_z: got %h/%b/%b want 31/0/1", p_z, p_sl, p_z_valid); end
        p_a0_valid = 1'b0;
        p_a1_valid = 1'b0;
        tick();
    endtask

    initial begin
        RN = 1'b1;
        r_a0 = '0; r_a0_valid = 1'b0; r_a0_last = 1'b0;
        r_a1 = '0; r_a1_valid = 1'b0; r_a1_last = 1'b0;
        r_z_ready = 1'b1;
        p_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        p_z_ready = 1'b1;

        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_watchdog();
        test_reset_mid_packet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
